// File: rtl/mem_wb_pipe_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_pipe_reg_if
//  Description : Stage-to-stage instruction bus with valid/ready flow control.
//                One instance carries MEM -> pipe register traffic, another
//                carries pipe register -> WB traffic.
//                  valid  : producer offers an entry
//                  ready  : consumer accepts (transfer = valid & ready)
//                  ir, pc : instruction word and its PC
//                  alu    : ALU result
//                  rd     : memory read data
//                  waddr  : destination register (0 = no write)
//                  tnew   : cycles until the result is ready
//                  bd     : entry is in a branch delay slot
//                Modports: master drives the payload, slave drives ready.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_wb_pipe_reg_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int TNEW_W = 2
);
   logic              valid;
   logic              ready;
   logic [31:0]       ir;
   logic [31:0]       pc;
   logic [DATA_W-1:0] alu;
   logic [DATA_W-1:0] rd;
   logic [ADDR_W-1:0] waddr;
   logic [TNEW_W-1:0] tnew;
   logic              bd;

   modport master (output valid, ir, pc, alu, rd, waddr, tnew, bd, input ready);
   modport slave  (input valid, ir, pc, alu, rd, waddr, tnew, bd, output ready);
endinterface
`default_nettype wire

// File: rtl/mem_wb_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_pipe_reg
//  Description : MEM -> WB pipeline register with valid/ready flow control,
//                flush, and per-cycle Tnew aging.
//                Optional feature macro: PIPE_REG_SKID_EN
//                  defined   : two-entry (head + skid) buffer, in_ready comes
//                              from registered state only
//                  undefined : single head entry, in_ready follows out_ready
//  Ports       : clk     - clock, rising edge
//                reset   - asynchronous active-high reset
//                flush   - synchronous drop of every held entry
//                in_if   - upstream bus (slave side)
//                out_if  - downstream bus (master side), head entry
//                out_pc4 - head pc + 4
//                out_pc8 - head pc + 8
//                fwd_ok  - head result may be forwarded now
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_pipe_reg #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int TNEW_W = 2
) (
   input  wire                clk,
   input  wire                reset,
   input  wire                flush,
   mem_wb_pipe_reg_if.slave   in_if,
   mem_wb_pipe_reg_if.master  out_if,
   output logic [31:0]        out_pc4,
   output logic [31:0]        out_pc8,
   output logic               fwd_ok
);

   typedef struct packed {
      logic              valid;
      logic [31:0]       ir;
      logic [31:0]       pc;
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] rd;
      logic [ADDR_W-1:0] waddr;
      logic [TNEW_W-1:0] tnew;
      logic              bd;
   } entry_t;

   // Saturating decrement: a result already available stays available.
   function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
      return (t == '0) ? t : t - TNEW_W'(1);
   endfunction

   entry_t r_head;
   entry_t w_head_nxt;
   entry_t w_cap;
   logic   w_in_ready;
   logic   w_in_xfer;
   logic   w_head_take;

`ifdef PIPE_REG_SKID_EN
   entry_t r_skid;
   entry_t w_skid_nxt;
`endif

   always_comb begin
      w_cap       = '0;
      w_cap.valid = 1'b1;
      w_cap.ir    = in_if.ir;
      w_cap.pc    = in_if.pc;
      w_cap.alu   = in_if.alu;
      w_cap.rd    = in_if.rd;
      w_cap.waddr = in_if.waddr;
      w_cap.tnew  = sat_dec(in_if.tnew);
      w_cap.bd    = in_if.bd;

`ifdef PIPE_REG_SKID_EN
      w_in_ready = !r_skid.valid && !flush;
`else
      w_in_ready = (!r_head.valid || out_if.ready) && !flush;
`endif
      w_in_xfer   = in_if.valid && w_in_ready;
      // Head slot is free this edge if empty or being consumed.
      w_head_take = !r_head.valid || out_if.ready;

      // Default: held entry ages by one cycle.
      w_head_nxt      = r_head;
      w_head_nxt.tnew = sat_dec(r_head.tnew);

`ifdef PIPE_REG_SKID_EN
      w_skid_nxt      = r_skid;
      w_skid_nxt.tnew = sat_dec(r_skid.tnew);
      if (w_head_take) begin
         if (r_skid.valid) begin
            // Older skid entry advances first to keep FIFO order.
            w_head_nxt      = r_skid;
            w_head_nxt.tnew = sat_dec(r_skid.tnew);
            w_skid_nxt      = w_in_xfer ? w_cap : '0;
         end else begin
            w_head_nxt = w_in_xfer ? w_cap : '0;
            w_skid_nxt = '0;
         end
      end else if (!r_skid.valid && w_in_xfer) begin
         w_skid_nxt = w_cap;
      end
      if (flush) begin
         w_head_nxt = '0;
         w_skid_nxt = '0;
      end
`else
      if (w_head_take) begin
         w_head_nxt = w_in_xfer ? w_cap : '0;
      end
      if (flush) begin
         w_head_nxt = '0;
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_head <= '0;
      end else begin
         r_head <= w_head_nxt;
      end
   end

`ifdef PIPE_REG_SKID_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_skid <= '0;
      end else begin
         r_skid <= w_skid_nxt;
      end
   end
`endif

   assign in_if.ready  = w_in_ready;
   assign out_if.valid = r_head.valid;
   assign out_if.ir    = r_head.ir;
   assign out_if.pc    = r_head.pc;
   assign out_if.alu   = r_head.alu;
   assign out_if.rd    = r_head.rd;
   assign out_if.waddr = r_head.waddr;
   assign out_if.tnew  = r_head.tnew;
   assign out_if.bd    = r_head.bd;
   assign out_pc4      = r_head.pc + 32'd4;
   assign out_pc8      = r_head.pc + 32'd8;
   assign fwd_ok       = r_head.valid && (r_head.waddr != '0) && (r_head.tnew == '0);

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_wb_pipe_reg
//  Description : Scoreboard bench for mem_wb_pipe_reg. Accepted inputs are
//                queued with their capture edge; the head of the queue is the
//                expected out_* entry, with Tnew aged by elapsed edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_pipe_reg;

`ifdef PIPE_REG_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   typedef struct {
      logic [31:0] ir;
      logic [31:0] pc;
      logic [31:0] alu;
      logic [31:0] rd;
      logic [4:0]  wa;
      logic [1:0]  tn;
      logic        bd;
      int          cap;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        flush;
   logic [31:0] out_pc4;
   logic [31:0] out_pc8;
   logic        fwd_ok;
   int          edges;
   int          n_checks;
   int          n_pass;
   exp_t        q[$];

   mem_wb_pipe_reg_if #(.DATA_W(32), .ADDR_W(5), .TNEW_W(2)) in_b ();
   mem_wb_pipe_reg_if #(.DATA_W(32), .ADDR_W(5), .TNEW_W(2)) out_b ();

   mem_wb_pipe_reg #(.DATA_W(32), .ADDR_W(5), .TNEW_W(2)) dut (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .in_if   (in_b),
      .out_if  (out_b),
      .out_pc4 (out_pc4),
      .out_pc8 (out_pc8),
      .fwd_ok  (fwd_ok)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial edges = 0;
   always @(posedge clk) edges <= edges + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // One clock cycle: drive inputs, check outputs against the scoreboard,
   // then update the scoreboard for the handshakes that occur at this edge.
   task automatic step(input logic v, input logic ordy, input logic fl,
                       input logic [31:0] ir, input logic [31:0] pc,
                       input logic [4:0] wa, input logic [1:0] tn);
      logic exp_rdy;
      exp_t e;
      int   age;
      logic [1:0] et;
      @(negedge clk);
      in_b.valid  = v;
      in_b.ir     = ir;
      in_b.pc     = pc;
      in_b.alu    = pc ^ 32'hA5A5_0000;
      in_b.rd     = ~ir;
      in_b.waddr  = wa;
      in_b.tnew   = tn;
      in_b.bd     = pc[2];
      out_b.ready = ordy;
      flush       = fl;
      #1;
      if (fl) exp_rdy = 1'b0;
      else if (SKID) exp_rdy = (q.size() < 2);
      else exp_rdy = (q.size() == 0) || ordy;
      check("in_ready", 64'(in_b.ready), 64'(exp_rdy));
      check("out_valid", 64'(out_b.valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
         e   = q[0];
         age = edges - e.cap + 1;
         et  = (int'(e.tn) > age) ? 2'(int'(e.tn) - age) : 2'd0;
         check("out_ir", 64'(out_b.ir), 64'(e.ir));
         check("out_pc", 64'(out_b.pc), 64'(e.pc));
         check("out_alu", 64'(out_b.alu), 64'(e.alu));
         check("out_rd", 64'(out_b.rd), 64'(e.rd));
         check("out_waddr", 64'(out_b.waddr), 64'(e.wa));
         check("out_tnew", 64'(out_b.tnew), 64'(et));
         check("out_bd", 64'(out_b.bd), 64'(e.bd));
         check("out_pc4", 64'(out_pc4), 64'(e.pc + 32'd4));
         check("out_pc8", 64'(out_pc8), 64'(e.pc + 32'd8));
         check("fwd_ok", 64'(fwd_ok), 64'((e.wa != 5'd0) && (et == 2'd0)));
      end else begin
         check("empty_ir", 64'(out_b.ir), 64'd0);
         check("empty_alu", 64'(out_b.alu), 64'd0);
         check("empty_pc4", 64'(out_pc4), 64'd4);
         check("empty_pc8", 64'(out_pc8), 64'd8);
         check("empty_fwd", 64'(fwd_ok), 64'd0);
      end
      if (fl) begin
         q.delete();
      end else begin
         if ((q.size() != 0) && ordy) void'(q.pop_front());
         if (v && exp_rdy) begin
            e.ir = ir; e.pc = pc; e.alu = pc ^ 32'hA5A5_0000; e.rd = ~ir;
            e.wa = wa; e.tn = tn; e.bd = pc[2]; e.cap = edges + 1;
            q.push_back(e);
         end
      end
      @(posedge clk);
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, ordy, 1'b0, 32'd0, 32'd0, 5'd0, 2'd0);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      reset    = 1'b1;
      flush    = 1'b0;
      in_b.valid = 1'b0; in_b.ir = '0; in_b.pc = '0; in_b.alu = '0; in_b.rd = '0;
      in_b.waddr = '0; in_b.tnew = '0; in_b.bd = 1'b0; out_b.ready = 1'b0;
      #12;
      // Reset state, observed while reset is still asserted.
      check("rst_out_valid", 64'(out_b.valid), 64'd0);
      check("rst_out_ir", 64'(out_b.ir), 64'd0);
      check("rst_out_pc8", 64'(out_pc8), 64'd8);
      check("rst_fwd_ok", 64'(fwd_ok), 64'd0);
      check("rst_in_ready", 64'(in_b.ready), 64'd1);
      @(negedge clk);
      reset = 1'b0;
      idle(1'b1);

      // Streaming at one instruction per cycle.
      for (int i = 0; i < 4; i++)
         step(1'b1, 1'b1, 1'b0, 32'h0100_0000 + 32'(i), 32'h3000 + 32'(4 * i), 5'(i + 1), 2'd2);
      idle(1'b1);
      idle(1'b1);

      // Tnew aging while held, forwarding readiness.
      step(1'b1, 1'b0, 1'b0, 32'hCAFE_0001, 32'h4000, 5'd5, 2'd2);
      idle(1'b0);
      idle(1'b0);
      idle(1'b1);
      step(1'b1, 1'b0, 1'b0, 32'hCAFE_0002, 32'h4004, 5'd0, 2'd0);
      idle(1'b0);
      idle(1'b1);
      idle(1'b1);

      // Back-pressure: push A, B, attempt C while stalled, then drain.
      step(1'b1, 1'b0, 1'b0, 32'hAAAA_0001, 32'h5000, 5'd7, 2'd3);
      step(1'b1, 1'b0, 1'b0, 32'hBBBB_0002, 32'h5004, 5'd8, 2'd1);
      step(1'b1, 1'b0, 1'b0, 32'hCCCC_0003, 32'h5008, 5'd9, 2'd1);
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);

      // Flush with storage full and input offered.
      step(1'b1, 1'b0, 1'b0, 32'hDDDD_0001, 32'h6000, 5'd3, 2'd1);
      step(1'b1, 1'b0, 1'b0, 32'hDDDD_0002, 32'h6004, 5'd4, 2'd1);
      step(1'b1, 1'b1, 1'b1, 32'hDDDD_0003, 32'h6008, 5'd6, 2'd1);
      idle(1'b0);
      idle(1'b1);

      // Asynchronous reset mid-stream, between edges.
      step(1'b1, 1'b0, 1'b0, 32'hEEEE_0001, 32'h7000, 5'd2, 2'd1);
      step(1'b1, 1'b0, 1'b0, 32'hEEEE_0002, 32'h7004, 5'd3, 2'd1);
      #2;
      in_b.valid = 1'b0;
      reset = 1'b1;
      #1;
      check("arst_out_valid", 64'(out_b.valid), 64'd0);
      check("arst_out_ir", 64'(out_b.ir), 64'd0);
      check("arst_out_pc8", 64'(out_pc8), 64'd8);
      check("arst_fwd_ok", 64'(fwd_ok), 64'd0);
      q.delete();
      @(negedge clk);
      reset = 1'b0;
      idle(1'b1);
      step(1'b1, 1'b1, 1'b0, 32'hF0F0_0001, 32'h8000, 5'd1, 2'd0);
      idle(1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_wb_pipe_reg.md
# mem_wb_pipe_reg

Parametrised MEM→WB pipeline register with valid/ready flow control, flush on exception/interrupt, and per-cycle Tnew aging. It sits between the memory stage and the write-back stage of the pipelined CPU. It buffers one or two in-flight instructions, depending on configuration, so a stalled write-back port does not lose data. It also supplies the hazard unit with forwarding-ready information for the held instruction.

## Interface
- DATA_W, 32: width of ALU-result and memory-read-data fields
- ADDR_W, 5: width of destination register address
- TNEW_W, 2: width of Tnew counter
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- flush  input  1  synchronous bubble insert (interrupt/exception), all entries dropped
- in_valid  input  1  upstream offers an instruction
- in_ready  output  1  block accepts this cycle (transfer = in_valid & in_ready)
- in_ir  input  32  instruction word
- in_pc  input  32  instruction PC
- in_alu  input  DATA_W  ALU result
- in_rd  input  DATA_W  memory read data
- in_waddr  input  ADDR_W  destination register (0 = no write)
- in_tnew  input  TNEW_W  cycles until result ready, as seen at MEM
- in_bd  input  1  instruction is in a branch delay slot
- out_valid  output  1  head entry valid
- out_ready  input  1  write-back consumes head (transfer = out_valid & out_ready)
- out_ir, out_pc  output  32  head entry fields
- out_pc4, out_pc8  output  32  out_pc+4, out_pc+8 (mod 2^32)
- out_alu, out_rd  output  DATA_W  head entry fields
- out_waddr  output  ADDR_W  head destination
- out_tnew  output  TNEW_W  head current Tnew
- out_bd  output  1  head delay-slot flag
- fwd_ok  output  1  out_valid & (out_waddr != 0) & (out_tnew == 0)

## Operation
- Storage: head register (drives out_*), plus skid register when PIPE_REG_SKID_EN is defined.
- Invalid entries hold all fields at 0; out_* of an empty head read 0, out_pc4=4, out_pc8=8.
- Tnew aging: on capture, stored tnew = sat_dec(in_tnew) (0 stays 0, else −1). Each cycle an entry is held (head or skid), its tnew = sat_dec(tnew).
- Head load: when head empty or head consumed this cycle, head loads skid entry if skid valid, else the input if transferring, else becomes empty.
- Skid load (SKID_EN): input transfer when head is occupied and not consumed, and no skid entry is held → stored in skid. Order strictly FIFO.
- Flush: both entries cleared to empty/zero at the next edge. Any in/out transfers in that cycle are discarded. in_ready forced 0 while flush=1. Flush wins over all simultaneous events.
- reset mid-operation: state zeroed asynchronously; in_ready comes up per the rules below once reset deasserts.

## Timing
- Latency: input transfer at edge N → out_valid=1 with that entry after edge N.
- Throughput: one instruction/cycle when out_ready held high.
- Reset values: out_valid=0, every data output 0 except out_pc4=4 and out_pc8=8, fwd_ok=0. in_ready=1 if not flushing.
- in_ready (SKID_EN): = !skid_valid & !flush; registered-state only, no combinational path from out_ready.
- in_ready (no SKID_EN): = (!out_valid | out_ready) & !flush.
- Full (SKID_EN, both valid): in_ready=0. Next edge with out_ready=1 moves skid→head and frees skid.
- Simultaneous consume and accept with skid valid: head←skid, skid←input.

## Configuration
- PIPE_REG_SKID_EN defined: 2-entry skid buffer and registered in_ready.
- PIPE_REG_SKID_EN undefined: single head entry; in_ready depends combinationally on out_ready; skid logic absent.

## Test plan
- Reset → out_valid=0, out_ir=0, out_pc8=8, fwd_ok=0, in_ready=1.
- Stream 4 instrs (pc=0x3000..0x300C), out_ready=1, in_tnew=2 → same order, one per cycle, 1-cycle latency, out_tnew=1, out_pc8=pc+8.
- Capture in_tnew=2, waddr=5; hold out_ready=0 2 cycles → out_tnew 1→0; fwd_ok rises when tnew=0. waddr=0 → fwd_ok stays 0.
- SKID_EN: out_ready=0, push A then B → in_ready=0 after B; out_ready=1 → A then B delivered, in_ready=1 after B moves to head.
- flush asserted with both entries full and in_valid=1 → next cycle out_valid=0, all outputs zero, input not captured.
- Assert reset mid-stream between edges → outputs zero immediately, without waiting for an edge.
